// File: rtl/csr_cmd_bridge.sv
// Byte-stream command bridge: host packets in, single-beat Avalon-MM CSR reads/writes out.
// Optional inter-byte timeout in GET_DATA is enabled by defining CSR_CMD_BRIDGE_BYTE_TIMEOUT_EN.
module csr_cmd_bridge #(
    parameter int unsigned RD_TIMEOUT   = 16,
    parameter int unsigned BYTE_TIMEOUT = 1000
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        read_o,
    output logic        write_o,
    output logic [3:0]  address_o,
    output logic [31:0] writedata_o,
    input  logic        readdatavalid_i,
    input  logic [31:0] readdata_i
);

    typedef enum logic [2:0] {
        StIdle, StGetData, StDoWr, StDoRd, StWaitRd, StSendStat, StSendData
    } state_e;

    localparam logic [7:0] RspWrOk   = 8'hA5;
    localparam logic [7:0] RspRdOk   = 8'h5A;
    localparam logic [7:0] RspBadOp  = 8'hE0;
    localparam logic [7:0] RspRdTmo  = 8'hE1;
    localparam logic [7:0] RdTmoLast = 8'(RD_TIMEOUT - 1);

    if (RD_TIMEOUT < 4 || RD_TIMEOUT > 255) begin : g_bad_rd_timeout
        $error("RD_TIMEOUT must be in 4..255");
    end
    if (BYTE_TIMEOUT == 0) begin : g_bad_byte_timeout
        $error("BYTE_TIMEOUT must be non-zero");
    end

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        rx_fire, tx_fire;

`ifdef CSR_CMD_BRIDGE_BYTE_TIMEOUT_EN
    localparam int unsigned BtoW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [BtoW-1:0] BtoLast = BtoW'(BYTE_TIMEOUT - 1);
    logic [BtoW-1:0] bto_q, bto_d;
`endif

    assign rx_ready_o = !rst_sys_i && (state_q == StIdle || state_q == StGetData);
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign tx_fire    = tx_valid_q && tx_ready_i;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        rdata_d    = rdata_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
`ifdef CSR_CMD_BRIDGE_BYTE_TIMEOUT_EN
        bto_d      = bto_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    addr_d = rx_data_i[3:0];
                    if (rx_data_i[6:4] != 3'b000) begin
                        state_d    = StSendStat;
                        tx_valid_d = 1'b1;
                        tx_data_d  = RspBadOp;
                    end else if (rx_data_i[7]) begin
                        state_d    = StGetData;
                        byte_cnt_d = 2'd0;
`ifdef CSR_CMD_BRIDGE_BYTE_TIMEOUT_EN
                        bto_d      = '0;
`endif
                    end else begin
                        state_d = StDoRd;
                    end
                end
            end
            StGetData: begin
                if (rx_fire) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = StDoWr;
                end
`ifdef CSR_CMD_BRIDGE_BYTE_TIMEOUT_EN
                // Stalled host: drop the partial packet without a strobe or a response.
                if (rx_fire) begin
                    bto_d = '0;
                end else if (bto_q == BtoLast) begin
                    bto_d   = '0;
                    state_d = StIdle;
                end else begin
                    bto_d = bto_q + BtoW'(1);
                end
`endif
            end
            StDoWr: begin
                state_d    = StSendStat;
                tx_valid_d = 1'b1;
                tx_data_d  = RspWrOk;
            end
            StDoRd: begin
                tmo_d   = 8'd0;
                state_d = StWaitRd;
            end
            StWaitRd: begin
                // Data arriving on the expiry cycle takes priority over the timeout.
                if (readdatavalid_i) begin
                    rdata_d    = readdata_i;
                    state_d    = StSendStat;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RspRdOk;
                end else if (tmo_q == RdTmoLast) begin
                    state_d    = StSendStat;
                    tx_valid_d = 1'b1;
                    tx_data_d  = RspRdTmo;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StSendStat: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    byte_cnt_d = 2'd0;
                    state_d    = (tx_data_q == RspRdOk) ? StSendData : StIdle;
                end
            end
            StSendData: begin
                // Valid drops for one cycle after each handshake while the next byte is loaded.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = rdata_q[{byte_cnt_q, 3'b000} +: 8];
                end else if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        read_d  = (state_d == StDoRd);
        write_d = (state_d == StDoWr);
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            tmo_q      <= 8'd0;
            rdata_q    <= 32'd0;
            wdata_q    <= 32'd0;
            addr_q     <= 4'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            rdata_q    <= rdata_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            read_q     <= read_d;
            write_q    <= write_d;
        end
    end

`ifdef CSR_CMD_BRIDGE_BYTE_TIMEOUT_EN
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) bto_q <= '0;
        else           bto_q <= bto_d;
    end
`endif

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign read_o      = read_q;
    assign write_o     = write_q;
    assign address_o   = addr_q;
    assign writedata_o = wdata_q;

endmodule

// File: tb/tb_csr_cmd_bridge.sv
// Randomized self-checking bench for csr_cmd_bridge against a packet-level response model.
module tb_csr_cmd_bridge;

    localparam int unsigned RdTimeout = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        rd, wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        rdv = 1'b0;
    logic [31:0] rdata = 32'h0;

    csr_cmd_bridge #(.RD_TIMEOUT(RdTimeout), .BYTE_TIMEOUT(50)) u_dut (
        .clk_sys_i       (clk),
        .rst_sys_i       (rst),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .rx_ready_o      (rx_ready),
        .tx_data_o       (tx_data),
        .tx_valid_o      (tx_valid),
        .tx_ready_i      (tx_ready),
        .read_o          (rd),
        .write_o         (wr),
        .address_o       (addr),
        .writedata_o     (wdata),
        .readdatavalid_i (rdv),
        .readdata_i      (rdata)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation logs, filled at the falling edge.
    int          cyc = 0;
    logic [7:0]  tx_log[$];
    logic [3:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [3:0]  rd_addr_log[$];
    int          rise_log[$];
    int          wr_cyc = -1, rd_cyc = -1, acc_cyc = -1;
    int          both_cnt = 0, unstable = 0, rdy_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        logic       txv_prev = 1'b0;
        logic       stall_prev = 1'b0;
        logic [7:0] data_prev = 8'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_valid && tx_ready) tx_log.push_back(tx_data);
                if (tx_valid && !txv_prev) rise_log.push_back(cyc);
                if (wr) begin
                    wr_addr_log.push_back(addr);
                    wr_data_log.push_back(wdata);
                    wr_cyc = cyc;
                end
                if (rd) begin
                    rd_addr_log.push_back(addr);
                    rd_cyc = cyc;
                end
                if (rd && wr) both_cnt++;
                if (tx_valid && rx_ready) rdy_bad++;
                if (stall_prev && (!tx_valid || tx_data != data_prev)) unstable++;
                if (rx_valid && rx_ready) acc_cyc = cyc;
                txv_prev   = tx_valid;
                stall_prev = tx_valid && !tx_ready;
                data_prev  = tx_data;
            end else begin
                txv_prev   = 1'b0;
                stall_prev = 1'b0;
            end
        end
    end

    // Response sink: 0 = always ready, 1 = random, 2 = hold off 10 cycles per byte.
    int bp_mode = 0;
    initial begin
        int stall = 0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: tx_ready = 1'($urandom);
                2: begin
                    if (!tx_valid) begin
                        tx_ready = 1'b0;
                        stall    = 0;
                    end else if (stall < 10) begin
                        tx_ready = 1'b0;
                        stall++;
                    end else begin
                        tx_ready = 1'b1;
                        stall    = 0;
                    end
                end
                default: tx_ready = 1'b1;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n = 0;
        logic acc = 1'b0;
        rx_valid = 1'b0;
        tick(gap);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("rx_accept", acc, 1'b1);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Slave side: answer the pending read lat cycles after read_o (lat 0 = never answer).
    task automatic serve_read(input int lat, input logic [31:0] d);
        int n = 0;
        while (!rd && n < 50) begin
            tick(1);
            n++;
        end
        check("read_strobe_seen", rd, 1'b1);
        if (lat > 0 && rd) begin
            tick(lat);
            rdv   = 1'b1;
            rdata = d;
            tick(1);
            rdv   = 1'b0;
            rdata = $urandom;
        end
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (tx_log.size() < target && n < 3000) begin
            tick(1);
            n++;
        end
        tick(3);
    endtask

    int last_acc = -1, first_rise = -1;

    // kind 0 = write, 1 = read, 2 = bad opcode (taken from d[7:0]).
    task automatic do_cmd(input int kind, input logic [3:0] a, input logic [31:0] d,
                          input int lat, input int gap);
        logic [7:0] exp_q[$];
        int tx0, wr0, rd0, rs0, nb;
        tx0 = tx_log.size();
        wr0 = wr_addr_log.size();
        rd0 = rd_addr_log.size();
        rs0 = rise_log.size();
        case (kind)
            0: begin
                send_byte({4'b1000, a}, gap);
                for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], gap);
                last_acc = acc_cyc;
                exp_q.push_back(8'hA5);
            end
            1: begin
                send_byte({4'b0000, a}, gap);
                last_acc = acc_cyc;
                serve_read(lat, d);
                if (lat == 0) begin
                    exp_q.push_back(8'hE1);
                end else begin
                    exp_q.push_back(8'h5A);
                    for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
                end
            end
            default: begin
                send_byte(d[7:0], gap);
                last_acc = acc_cyc;
                exp_q.push_back(8'hE0);
            end
        endcase
        wait_rsp(tx0 + exp_q.size());
        nb = tx_log.size() - tx0;
        check("rsp_len", nb, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < nb; i++) check("rsp_byte", tx_log[tx0+i], exp_q[i]);
        check("wr_count", wr_addr_log.size() - wr0, (kind == 0) ? 1 : 0);
        if (kind == 0 && wr_addr_log.size() > wr0) begin
            check("wr_addr", wr_addr_log[wr0], a);
            check("wr_data", wr_data_log[wr0], d);
        end
        check("rd_count", rd_addr_log.size() - rd0, (kind == 1) ? 1 : 0);
        if (kind == 1 && rd_addr_log.size() > rd0) check("rd_addr", rd_addr_log[rd0], a);
        check("rx_ready_after_rsp", rx_ready, 1'b1);
        first_rise = (rise_log.size() > rs0) ? rise_log[rs0] : -1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0, wr0, kind, lat, gap;
        logic [31:0] d;
        logic [3:0]  a;

        // Reset values.
        @(negedge clk);
        check("rst_read", rd, 1'b0);
        check("rst_write", wr, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_address", addr, 4'h0);
        check("rst_writedata", wdata, 32'h0);
        check("rst_rx_ready", rx_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", rx_ready, 1'b1);
        tick(1);

        // Write with latency checks.
        do_cmd(0, 4'h2, 32'h12345678, 0, 0);
        check("wr_strobe_cycle", wr_cyc, last_acc + 1);
        check("wr_rsp_cycle", first_rise, last_acc + 2);
        check("wdata_hold", wdata, 32'h12345678);

        // Read from a 2-cycle slave.
        do_cmd(1, 4'h5, 32'hDEADBEEF, 2, 0);
        check("rd_strobe_cycle", rd_cyc, last_acc + 1);
        check("rd_rsp_cycle", first_rise, last_acc + 4);
        check("addr_hold", addr, 4'h5);

        // Bad opcode, then a normal read.
        do_cmd(2, 4'h0, 32'h30, 0, 0);
        do_cmd(1, 4'h1, 32'h0F1E2D3C, 3, 1);

        // Read timeout, then a late readdatavalid that must be ignored.
        do_cmd(1, 4'h3, 32'h0, 0, 0);
        check("tmo_rsp_cycle", first_rise, rd_cyc + RdTimeout + 1);
        tx0 = tx_log.size();
        tick(2);
        rdv   = 1'b1;
        rdata = 32'hCAFEF00D;
        tick(1);
        rdv = 1'b0;
        tick(10);
        check("late_rdv_ignored", tx_log.size(), tx0);
        check("late_rdv_no_valid", tx_valid, 1'b0);

        // Data on the expiry cycle wins over the timeout.
        do_cmd(1, 4'h9, 32'h13579BDF, RdTimeout, 0);

        // Back-pressure on every response byte.
        bp_mode = 2;
        do_cmd(1, 4'hC, 32'h0BADF00D, 3, 0);
        bp_mode = 0;
        tick(2);

        // Inter-byte gap inside a write packet.
        tx0 = tx_log.size();
        wr0 = wr_addr_log.size();
        send_byte(8'h81, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        tick(51);
`ifdef CSR_CMD_BRIDGE_BYTE_TIMEOUT_EN
        check("bto_no_write", wr_addr_log.size() - wr0, 0);
        check("bto_no_rsp", tx_log.size() - tx0, 0);
        do_cmd(0, 4'h4, 32'hDDCCBBAA, 0, 0);
`else
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        wait_rsp(tx0 + 1);
        check("gap_rsp_len", tx_log.size() - tx0, 1);
        if (tx_log.size() > tx0) check("gap_rsp_byte", tx_log[tx0], 8'hA5);
        check("gap_wr_count", wr_addr_log.size() - wr0, 1);
        if (wr_addr_log.size() > wr0) begin
            check("gap_wr_addr", wr_addr_log[wr0], 4'h1);
            check("gap_wr_data", wr_data_log[wr0], 32'h44332211);
        end
`endif

        // Reset in the middle of a write packet.
        wr0 = wr_addr_log.size();
        send_byte(8'h87, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rx_ready", rx_ready, 1'b0);
        check("midrst_writedata", wdata, 32'h0);
        check("midrst_address", addr, 4'h0);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("midrst_no_write", wr_addr_log.size() - wr0, 0);
        check("midrst_idle_valid", tx_valid, 1'b0);
        do_cmd(0, 4'h7, 32'hA1B2C3D4, 0, 0);

        // Randomized command mix with random sink back-pressure.
        bp_mode = 1;
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 2));
            lat  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, RdTimeout));
            gap  = int'($urandom_range(0, 2));
            a    = 4'($urandom);
            d    = $urandom;
            if (kind == 2) d = {24'h0, 1'($urandom), 3'($urandom_range(1, 7)), a};
            do_cmd(kind, a, d, lat, gap);
        end
        bp_mode = 0;
        tick(2);

        check("never_both_strobes", both_cnt, 0);
        check("tx_stable_when_stalled", unstable, 0);
        check("rx_ready_low_during_rsp", rdy_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
